// File: rtl/adc_pkg.sv
// Shared definitions for the ADC channel sequencer: register map, CTRL/STATUS
// bit positions and FSM state encoding.
package adc_pkg;

   localparam logic [2:0] ADDR_CHANNEL = 3'd0;
   localparam logic [2:0] ADDR_CTRL    = 3'd1;
   localparam logic [2:0] ADDR_MASK    = 3'd2;
   localparam logic [2:0] ADDR_DWELL   = 3'd3;
   localparam logic [2:0] ADDR_STATUS  = 3'd4;

   localparam int CTRL_MODE   = 0;
   localparam int CTRL_RUN    = 1;
   localparam int CTRL_CONT   = 2;
   localparam int CTRL_IRQ_EN = 3;

   localparam int STAT_BUSY   = 0;
   localparam int STAT_DONE   = 1;
   localparam int STAT_CH_LSB = 8;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SETTLE = 1'b1
   } seq_state_t;

endpackage

// File: rtl/adc_next_channel.sv
// Combinational scan helper: next enabled channel strictly above the current one
// (wrapping to the lowest enabled channel) and the lowest enabled channel.
module adc_next_channel #(
   parameter int NUM_CH = 8,
   parameter int CH_W   = 3
) (
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   cur,
   output logic [CH_W-1:0]   next_ch,
   output logic              wrap,
   output logic [CH_W-1:0]   lowest_ch
);

   logic [NUM_CH-1:0] above;
   logic [CH_W-1:0]   above_idx;
   logic [CH_W-1:0]   low_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_above
         assign above[gi] = mask[gi] && (gi > int'(cur));
      end
   endgenerate

   // Scanning downward leaves the lowest set index in each result.
   always_comb begin
      above_idx = '0;
      low_idx   = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (above[i]) above_idx = CH_W'(i);
         if (mask[i])  low_idx   = CH_W'(i);
      end
   end

   assign wrap      = ~|above;
   assign next_ch   = wrap ? low_idx : above_idx;
   assign lowest_ch = low_idx;

endmodule

// File: rtl/adc_channel_sequencer.sv
// Avalon-MM ADC mux channel sequencer: manual channel select or hardware scan
// over a channel mask with programmable dwell, sample strobes and sweep IRQ.
module adc_channel_sequencer
   import adc_pkg::*;
#(
   parameter int NUM_CH  = 8,
   parameter int CH_W    = $clog2(NUM_CH),
   parameter int DWELL_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [CH_W-1:0]   out_port,
   output logic              ch_valid,
   output logic              sweep_done,
   output logic              irq
);

   seq_state_t         state_reg, state_next;
   logic [DWELL_W-1:0] cnt_reg, cnt_next;
   logic [CH_W-1:0]    out_port_reg, out_port_next;
   logic [CH_W-1:0]    channel_reg;
   logic               mode_reg, run_reg, cont_reg, irq_en_reg;
   logic [NUM_CH-1:0]  mask_reg;
   logic [DWELL_W-1:0] dwell_reg;
   logic               done_reg, irq_reg;

   logic               wr, wr_channel, wr_ctrl, wr_mask, wr_dwell, wr_status;
   logic [CH_W-1:0]    channel_eff;
   logic               mode_eff, abort, run_clr, busy;
   logic [DWELL_W-1:0] dwell_load;
   logic [CH_W-1:0]    next_ch, lowest_ch;
   logic               wrap;
   logic               unused_bits;

   assign wr         = chipselect & ~write_n;
   assign wr_channel = wr && (address == ADDR_CHANNEL);
   assign wr_ctrl    = wr && (address == ADDR_CTRL);
   assign wr_mask    = wr && (address == ADDR_MASK);
   assign wr_dwell   = wr && (address == ADDR_DWELL);
   assign wr_status  = wr && (address == ADDR_STATUS);

   // Same-cycle writes are forwarded so manual selection lands on the next edge.
   assign channel_eff = wr_channel ? writedata[CH_W-1:0] : channel_reg;
   assign mode_eff    = wr_ctrl ? writedata[CTRL_MODE] : mode_reg;
   assign abort       = (wr_ctrl && !(writedata[CTRL_RUN] && writedata[CTRL_MODE]))
                        || !run_reg || !mode_reg;
   assign dwell_load  = (dwell_reg == '0) ? '0 : dwell_reg - 1'b1;
   assign busy        = (state_reg == ST_SETTLE);
   assign unused_bits = &{1'b0, writedata};

   adc_next_channel #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_next (
      .mask      (mask_reg),
      .cur       (out_port_reg),
      .next_ch   (next_ch),
      .wrap      (wrap),
      .lowest_ch (lowest_ch)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= '0;
         out_port_reg <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         out_port_reg <= out_port_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      out_port_next = out_port_reg;
      ch_valid      = 1'b0;
      sweep_done    = 1'b0;
      run_clr       = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!mode_eff) begin
               out_port_next = channel_eff;
            end else if (mode_reg && run_reg) begin
               if (mask_reg != '0) begin
                  state_next    = ST_SETTLE;
                  out_port_next = lowest_ch;
                  cnt_next      = dwell_load;
               end else begin
                  run_clr = 1'b1;
               end
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_next = ST_IDLE;
               if (!mode_eff) out_port_next = channel_eff;
            end else if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               ch_valid = 1'b1;
               // An emptied mask ends the scan like a one-shot sweep.
               if (wrap && (!cont_reg || (mask_reg == '0))) begin
                  sweep_done = 1'b1;
                  run_clr    = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  sweep_done    = wrap;
                  out_port_next = next_ch;
                  cnt_next      = dwell_load;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         channel_reg <= '0;
         mode_reg    <= 1'b0;
         run_reg     <= 1'b0;
         cont_reg    <= 1'b0;
         irq_en_reg  <= 1'b0;
         mask_reg    <= '0;
         dwell_reg   <= '0;
         done_reg    <= 1'b0;
         irq_reg     <= 1'b0;
      end else begin
         if (wr_channel) channel_reg <= writedata[CH_W-1:0];
         if (run_clr)    run_reg     <= 1'b0;
         if (wr_ctrl) begin
            mode_reg   <= writedata[CTRL_MODE];
            run_reg    <= writedata[CTRL_RUN];
            cont_reg   <= writedata[CTRL_CONT];
            irq_en_reg <= writedata[CTRL_IRQ_EN];
         end
         if (wr_mask)  mask_reg  <= writedata[NUM_CH-1:0];
         if (wr_dwell) dwell_reg <= writedata[DWELL_W-1:0];
         if (sweep_done)
            done_reg <= 1'b1;
         else if (wr_status && writedata[STAT_DONE])
            done_reg <= 1'b0;
         irq_reg <= done_reg & irq_en_reg;
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CHANNEL: readdata[CH_W-1:0]    = channel_reg;
         ADDR_CTRL:    readdata[3:0]         = {irq_en_reg, cont_reg, run_reg, mode_reg};
         ADDR_MASK:    readdata[NUM_CH-1:0]  = mask_reg;
         ADDR_DWELL:   readdata[DWELL_W-1:0] = dwell_reg;
         ADDR_STATUS: begin
            readdata[STAT_BUSY]             = busy;
            readdata[STAT_DONE]             = done_reg;
            readdata[STAT_CH_LSB +: CH_W]   = out_port_reg;
         end
         default: readdata = '0;
      endcase
   end

   assign out_port = out_port_reg;
   assign irq      = irq_reg;

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// Directed self-checking bench for adc_channel_sequencer: manual mode, single
// and continuous sweeps, IRQ/W1C, abort, empty mask and asynchronous reset.
module tb_adc_channel_sequencer;

   logic        clk;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [2:0]  out_port;
   logic        ch_valid;
   logic        sweep_done;
   logic        irq;

   int checks = 0;
   int errors = 0;

   adc_channel_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .ch_valid   (ch_valid),
      .sweep_done (sweep_done),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Drive on a falling edge; the write is taken on the following rising edge.
   task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
      @(negedge clk);
      address    = addr;
      writedata  = data;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
      address    = addr;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      data       = readdata;
      chipselect = 1'b0;
   endtask

   logic [31:0] rd;
   logic [2:0]  sweep_seq [3];
   logic        seen_valid;

   initial begin
      sweep_seq[0] = 3'd0;
      sweep_seq[1] = 3'd3;
      sweep_seq[2] = 3'd5;
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      repeat (3) @(negedge clk);
      check_value("reset out_port", 32'(out_port), 32'd0);
      check_value("reset irq", 32'(irq), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      bus_read(3'd4, rd);
      check_value("reset STATUS", rd, 32'h0);

      // 1: manual channel select
      bus_write(3'd1, 32'h0);
      bus_write(3'd0, 32'd5);
      check_value("manual out_port", 32'(out_port), 32'd5);
      seen_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (ch_valid || sweep_done) seen_valid = 1'b1;
      end
      check_value("manual no strobe", 32'(seen_valid), 32'd0);

      // 2: single sweep over channels 0,3,5 with dwell 4
      bus_write(3'd2, 32'h29);
      bus_write(3'd3, 32'd4);
      bus_write(3'd1, 32'h3);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check_value($sformatf("sweep out_port[%0d]", k), 32'(out_port), 32'(sweep_seq[k / 4]));
         check_value($sformatf("sweep ch_valid[%0d]", k), 32'(ch_valid), 32'((k % 4) == 3));
         check_value($sformatf("sweep done[%0d]", k), 32'(sweep_done), 32'(k == 11));
      end
      @(negedge clk);
      check_value("sweep end out_port", 32'(out_port), 32'd5);
      check_value("sweep end ch_valid", 32'(ch_valid), 32'd0);
      bus_read(3'd4, rd);
      check_value("sweep end STATUS", rd, 32'h502);
      bus_read(3'd1, rd);
      check_value("sweep end CTRL", rd, 32'h1);
      check_value("sweep irq disabled", 32'(irq), 32'd0);
      bus_write(3'd4, 32'h2);
      bus_read(3'd4, rd);
      check_value("W1C clear STATUS", rd, 32'h500);

      // 3: continuous single-channel scan, dwell 0, irq enabled
      bus_write(3'd2, 32'h80);
      bus_write(3'd3, 32'd0);
      bus_write(3'd1, 32'hF);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_value($sformatf("cont out_port[%0d]", k), 32'(out_port), 32'd7);
         check_value($sformatf("cont ch_valid[%0d]", k), 32'(ch_valid), 32'd1);
         check_value($sformatf("cont done[%0d]", k), 32'(sweep_done), 32'd1);
         check_value($sformatf("cont irq[%0d]", k), 32'(irq), 32'(k >= 2));
      end
      bus_write(3'd4, 32'h2);
      bus_read(3'd4, rd);
      check_value("W1C set wins STATUS", rd, 32'h703);
      check_value("cont irq held", 32'(irq), 32'd1);
      bus_write(3'd1, 32'h0);
      check_value("stop to manual out_port", 32'(out_port), 32'd5);
      bus_write(3'd4, 32'h2);
      bus_read(3'd4, rd);
      check_value("stop STATUS", rd, 32'h500);
      @(negedge clk);
      check_value("irq cleared", 32'(irq), 32'd0);

      // 4: abort a continuous scan at cnt=3
      bus_write(3'd2, 32'hFF);
      bus_write(3'd3, 32'd10);
      bus_write(3'd1, 32'h7);
      seen_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (ch_valid) seen_valid = 1'b1;
      end
      check_value("abort pre busy out_port", 32'(out_port), 32'd0);
      bus_write(3'd1, 32'h1);
      bus_read(3'd4, rd);
      check_value("abort STATUS", rd, 32'h0);
      repeat (12) begin
         @(negedge clk);
         if (ch_valid || sweep_done) seen_valid = 1'b1;
      end
      check_value("abort no ch_valid", 32'(seen_valid), 32'd0);
      check_value("abort out_port held", 32'(out_port), 32'd0);

      // 5: empty mask in scan mode
      bus_write(3'd0, 32'd6);
      bus_write(3'd1, 32'h0);
      check_value("manual ch6 out_port", 32'(out_port), 32'd6);
      bus_write(3'd2, 32'h0);
      bus_write(3'd1, 32'h3);
      @(negedge clk);
      bus_read(3'd1, rd);
      check_value("empty mask CTRL", rd, 32'h1);
      bus_read(3'd4, rd);
      check_value("empty mask STATUS", rd, 32'h600);
      check_value("empty mask out_port", 32'(out_port), 32'd6);

      // 6: asynchronous reset during a continuous scan of channels 1,2
      bus_write(3'd2, 32'h06);
      bus_write(3'd3, 32'd3);
      bus_write(3'd1, 32'hF);
      repeat (10) @(negedge clk);
      check_value("pre-reset out_port", 32'(out_port), 32'd2);
      check_value("pre-reset irq", 32'(irq), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_value("async reset out_port", 32'(out_port), 32'd0);
      check_value("async reset irq", 32'(irq), 32'd0);
      check_value("async reset strobes", 32'({ch_valid, sweep_done}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int a = 0; a < 6; a++) begin
         bus_read(3'(a), rd);
         check_value($sformatf("post-reset reg%0d", a), rd, 32'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
